bram_access_arbiter: RTL and testbench

Shares a dual-port BRAM (two ports, each with independent read and write addresses and 1-cycle registered read) among p_REQUESTERS clients. Each cycle, up to two requests are granted, one per port, in round-robin order. Grants that would collide on the same address are suppressed. Each read's data is routed back to its owner exactly one cycle after the grant. The block sits between client engines and the dual-port BRAM and is the only agent driving the BRAM port controls.

---
 rtl/bram_arb_pkg.sv | 29 ++
 rtl/bram_rr_picker.sv | 38 +++
 rtl/bram_access_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_bram_access_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// Shared definitions for the dual-port BRAM access arbiter.
// Holds the response latency, the grant conflict rule and a clog2 helper.
package bram_arb_pkg;

  // BRAM read data is returned one cycle after the grant.
  localparam int unsigned RSP_LATENCY = 1;

  // Widest address the conflict rule compares; callers zero-extend into it.
  localparam int unsigned MAX_ADDRESS_WIDTH = 32;
  typedef logic [MAX_ADDRESS_WIDTH-1:0] addr_word_t;

  // Ceiling log2, never less than 1 so a select index always has a bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((32'd1 << width) < value) width++;
    return width;
  endfunction

  // Two accesses may not share a cycle when they hit the same address and
  // at least one of them writes; two reads of one address are harmless.
  function automatic logic is_conflict(input addr_word_t addr_x,
                                       input addr_word_t addr_y,
                                       input logic       write_x,
                                       input logic       write_y);
    return (addr_x == addr_y) && (write_x || write_y);
  endfunction

endpackage

// File: rtl/bram_rr_picker.sv
// Rotating first-set-bit picker: scans the request mask starting at the
// start index, wrapping around, and reports the first set bit one-hot and
// encoded.
module bram_rr_picker #(
  parameter int unsigned p_WIDTH       = 4,
  parameter int unsigned p_INDEX_WIDTH = 2
) (
  input  logic [p_WIDTH-1:0]       mask,
  input  logic [p_INDEX_WIDTH-1:0] start,
  output logic [p_WIDTH-1:0]       grant,
  output logic [p_INDEX_WIDTH-1:0] index,
  output logic                     found
);

  // Walk candidates start, start+1, ... modulo p_WIDTH; keep the first hit.
  always_comb begin
    logic [p_INDEX_WIDTH:0]   sum;
    logic [p_INDEX_WIDTH-1:0] cand;
    grant = '0;
    index = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < p_WIDTH; i++) begin
      sum = {1'b0, start} + (p_INDEX_WIDTH+1)'(i);
      if (sum >= (p_INDEX_WIDTH+1)'(p_WIDTH)) begin
        sum = sum - (p_INDEX_WIDTH+1)'(p_WIDTH);
      end
      cand = sum[p_INDEX_WIDTH-1:0];
      if (!found && mask[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule

// File: rtl/bram_access_arbiter.sv
// Dual-port BRAM access arbiter: grants up to two clients per cycle (one per
// BRAM port), suppresses same-address grants involving a write, drives the
// BRAM strobes combinationally and routes read data back to its owner one
// cycle later.
// Build option: BRAM_ARB_FIXED_PRIORITY_EN replaces the round-robin pointer
// with fixed priority (client 0 highest).
module bram_access_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned p_REQUESTERS    = 4,
  parameter int unsigned p_ADDRESS_WIDTH = 4,
  parameter int unsigned p_DATA_WIDTH    = 8
) (
  input  logic                                   i_CLK,
  input  logic                                   i_RESET,
  input  logic [p_REQUESTERS-1:0]                i_REQ_VALID,
  input  logic [p_REQUESTERS-1:0]                i_REQ_WRITE,
  input  logic [p_REQUESTERS*p_ADDRESS_WIDTH-1:0] i_REQ_ADDRESS,
  input  logic [p_REQUESTERS*p_DATA_WIDTH-1:0]   i_REQ_DATA,
  output logic [p_REQUESTERS-1:0]                o_REQ_READY,
  output logic [p_REQUESTERS-1:0]                o_RSP_VALID,
  output logic [p_REQUESTERS*p_DATA_WIDTH-1:0]   o_RSP_DATA,
  output logic                                   o_BRAM_READ_ENABLE_A,
  output logic                                   o_BRAM_READ_ENABLE_B,
  output logic                                   o_BRAM_WRITE_ENABLE_A,
  output logic                                   o_BRAM_WRITE_ENABLE_B,
  output logic [p_ADDRESS_WIDTH-1:0]             o_BRAM_READ_ADDRESS_A,
  output logic [p_ADDRESS_WIDTH-1:0]             o_BRAM_READ_ADDRESS_B,
  output logic [p_ADDRESS_WIDTH-1:0]             o_BRAM_WRITE_ADDRESS_A,
  output logic [p_ADDRESS_WIDTH-1:0]             o_BRAM_WRITE_ADDRESS_B,
  output logic [p_DATA_WIDTH-1:0]                o_BRAM_WRITE_DATA_A,
  output logic [p_DATA_WIDTH-1:0]                o_BRAM_WRITE_DATA_B,
  input  logic [p_DATA_WIDTH-1:0]                i_BRAM_READ_DATA_A,
  input  logic [p_DATA_WIDTH-1:0]                i_BRAM_READ_DATA_B
);

  localparam int unsigned PW = clog2(p_REQUESTERS);
  localparam logic [PW-1:0] LAST_IDX = PW'(p_REQUESTERS - 1);

  logic [p_ADDRESS_WIDTH-1:0] req_addr [p_REQUESTERS];
  logic [p_DATA_WIDTH-1:0]    req_data [p_REQUESTERS];

  logic [p_REQUESTERS-1:0] req_mask;
  logic [p_REQUESTERS-1:0] conflict_mask;
  logic [p_REQUESTERS-1:0] b_mask;
  logic [p_REQUESTERS-1:0] a_grant;
  logic [p_REQUESTERS-1:0] b_grant;
  logic [PW-1:0]           a_idx;
  logic [PW-1:0]           b_idx;
  logic                    a_found;
  logic                    b_found;
  logic                    a_write;
  logic                    b_write;
  logic [PW-1:0]           start_idx;

  logic          r_pend_a;
  logic          r_pend_b;
  logic [PW-1:0] r_owner_a;
  logic [PW-1:0] r_owner_b;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  // Split the flattened request buses into per-client fields.
  always_comb begin
    for (int unsigned k = 0; k < p_REQUESTERS; k++) begin
      req_addr[k] = i_REQ_ADDRESS[k*p_ADDRESS_WIDTH +: p_ADDRESS_WIDTH];
      req_data[k] = i_REQ_DATA[k*p_DATA_WIDTH +: p_DATA_WIDTH];
    end
  end

  // Reset masks every request, which keeps ready and all strobes low.
  assign req_mask = i_RESET ? '0 : i_REQ_VALID;

`ifdef BRAM_ARB_FIXED_PRIORITY_EN
  assign start_idx = '0;
`else
  logic [PW-1:0] r_ptr;
  assign start_idx = r_ptr;
`endif

  bram_rr_picker #(
    .p_WIDTH       (p_REQUESTERS),
    .p_INDEX_WIDTH (PW)
  ) u_pick_a (
    .mask  (req_mask),
    .start (start_idx),
    .grant (a_grant),
    .index (a_idx),
    .found (a_found)
  );

  // Flag every other valid client whose access collides with the A winner.
  always_comb begin
    conflict_mask = '0;
    for (int unsigned k = 0; k < p_REQUESTERS; k++) begin
      if (a_found && req_mask[k] && !a_grant[k] &&
          is_conflict(addr_word_t'(req_addr[k]), addr_word_t'(req_addr[a_idx]),
                      i_REQ_WRITE[k], i_REQ_WRITE[a_idx])) begin
        conflict_mask[k] = 1'b1;
      end
    end
  end

  // Clients before the A winner are invalid, so starting B at the same index
  // with A removed yields the next eligible client after A.
  assign b_mask = req_mask & ~a_grant & ~conflict_mask;

  bram_rr_picker #(
    .p_WIDTH       (p_REQUESTERS),
    .p_INDEX_WIDTH (PW)
  ) u_pick_b (
    .mask  (b_mask),
    .start (start_idx),
    .grant (b_grant),
    .index (b_idx),
    .found (b_found)
  );

  assign o_REQ_READY = a_grant | b_grant;
  assign a_write     = a_found && i_REQ_WRITE[a_idx];
  assign b_write     = b_found && i_REQ_WRITE[b_idx];

  // Drive both BRAM ports from the winners; idle ports are fully zeroed.
  always_comb begin
    o_BRAM_READ_ENABLE_A   = 1'b0;
    o_BRAM_WRITE_ENABLE_A  = 1'b0;
    o_BRAM_READ_ADDRESS_A  = '0;
    o_BRAM_WRITE_ADDRESS_A = '0;
    o_BRAM_WRITE_DATA_A    = '0;
    o_BRAM_READ_ENABLE_B   = 1'b0;
    o_BRAM_WRITE_ENABLE_B  = 1'b0;
    o_BRAM_READ_ADDRESS_B  = '0;
    o_BRAM_WRITE_ADDRESS_B = '0;
    o_BRAM_WRITE_DATA_B    = '0;
    if (a_found) begin
      o_BRAM_READ_ADDRESS_A  = req_addr[a_idx];
      o_BRAM_WRITE_ADDRESS_A = req_addr[a_idx];
      o_BRAM_READ_ENABLE_A   = !a_write;
      o_BRAM_WRITE_ENABLE_A  = a_write;
      if (a_write) o_BRAM_WRITE_DATA_A = req_data[a_idx];
    end
    if (b_found) begin
      o_BRAM_READ_ADDRESS_B  = req_addr[b_idx];
      o_BRAM_WRITE_ADDRESS_B = req_addr[b_idx];
      o_BRAM_READ_ENABLE_B   = !b_write;
      o_BRAM_WRITE_ENABLE_B  = b_write;
      if (b_write) o_BRAM_WRITE_DATA_B = req_data[b_idx];
    end
  end

`ifndef BRAM_ARB_FIXED_PRIORITY_EN
  // Advance the round-robin pointer past the last client served this cycle.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      r_ptr <= '0;
    end else if (a_found) begin
      if (|conflict_mask) begin
        r_ptr <= wrap_inc(a_idx);
      end else if (b_found) begin
        r_ptr <= wrap_inc(b_idx);
      end else begin
        r_ptr <= wrap_inc(a_idx);
      end
    end
  end
`endif

  // Remember which client owns each port's read data arriving next cycle.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      r_pend_a  <= 1'b0;
      r_pend_b  <= 1'b0;
      r_owner_a <= '0;
      r_owner_b <= '0;
    end else begin
      r_pend_a  <= a_found && !a_write;
      r_pend_b  <= b_found && !b_write;
      r_owner_a <= a_idx;
      r_owner_b <= b_idx;
    end
  end

  // Route returning read data to its owner; reset drops in-flight responses.
  always_comb begin
    o_RSP_VALID = '0;
    o_RSP_DATA  = '0;
    for (int unsigned k = 0; k < p_REQUESTERS; k++) begin
      if (!i_RESET && r_pend_a && (r_owner_a == PW'(k))) begin
        o_RSP_VALID[k]                            = 1'b1;
        o_RSP_DATA[k*p_DATA_WIDTH +: p_DATA_WIDTH] = i_BRAM_READ_DATA_A;
      end
      if (!i_RESET && r_pend_b && (r_owner_b == PW'(k))) begin
        o_RSP_VALID[k]                            = 1'b1;
        o_RSP_DATA[k*p_DATA_WIDTH +: p_DATA_WIDTH] = i_BRAM_READ_DATA_B;
      end
    end
  end

endmodule

// File: tb/tb_bram_access_arbiter.sv
// Directed, table-driven bench for bram_access_arbiter with a behavioural
// dual-port BRAM (registered reads) attached.
module tb_bram_access_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  valid;
  logic [3:0]  write;
  logic [15:0] addr;
  logic [31:0] data;
  logic [3:0]  ready;
  logic [3:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        re_a, re_b, we_a, we_b;
  logic [3:0]  ra_a, ra_b, wa_a, wa_b;
  logic [7:0]  wd_a, wd_b;
  logic [7:0]  rd_a, rd_b;

  logic [7:0] mem [16] = '{1: 8'h11, 2: 8'h22, 3: 8'h33, 4: 8'h44, default: 8'h00};

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  write;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  exp_ready;
    logic [3:0]  exp_en;      // {we_b, re_b, we_a, re_a}
    logic [3:0]  exp_rsp_valid;
    logic [31:0] exp_rsp_data;
    logic [3:0]  exp_addr_a;
    logic [3:0]  exp_addr_b;
    logic [7:0]  exp_wdata_a;
  } vec_t;

  vec_t vecs[$];

  bram_access_arbiter #(
    .p_REQUESTERS    (4),
    .p_ADDRESS_WIDTH (4),
    .p_DATA_WIDTH    (8)
  ) dut (
    .i_CLK                  (clk),
    .i_RESET                (rst),
    .i_REQ_VALID            (valid),
    .i_REQ_WRITE            (write),
    .i_REQ_ADDRESS          (addr),
    .i_REQ_DATA             (data),
    .o_REQ_READY            (ready),
    .o_RSP_VALID            (rsp_valid),
    .o_RSP_DATA             (rsp_data),
    .o_BRAM_READ_ENABLE_A   (re_a),
    .o_BRAM_READ_ENABLE_B   (re_b),
    .o_BRAM_WRITE_ENABLE_A  (we_a),
    .o_BRAM_WRITE_ENABLE_B  (we_b),
    .o_BRAM_READ_ADDRESS_A  (ra_a),
    .o_BRAM_READ_ADDRESS_B  (ra_b),
    .o_BRAM_WRITE_ADDRESS_A (wa_a),
    .o_BRAM_WRITE_ADDRESS_B (wa_b),
    .o_BRAM_WRITE_DATA_A    (wd_a),
    .o_BRAM_WRITE_DATA_B    (wd_b),
    .i_BRAM_READ_DATA_A     (rd_a),
    .i_BRAM_READ_DATA_B     (rd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Dual-port BRAM model with one-cycle registered read.
  always @(posedge clk) begin
    if (we_a) mem[wa_a] <= wd_a;
    if (we_b) mem[wa_b] <= wd_b;
    if (re_a) rd_a <= mem[ra_a];
    if (re_b) rd_b <= mem[ra_b];
  end

  task automatic check(input string name, input int row,
                       input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, got, exp);
    end
  endtask

  task automatic add_vec(input logic r, input logic [3:0] v, input logic [3:0] w,
                         input logic [15:0] a, input logic [31:0] d,
                         input logic [3:0] e_rdy, input logic [3:0] e_en,
                         input logic [3:0] e_rv, input logic [31:0] e_rd,
                         input logic [3:0] e_aa, input logic [3:0] e_ab,
                         input logic [7:0] e_wa);
    vec_t t;
    t.rst = r; t.valid = v; t.write = w; t.addr = a; t.data = d;
    t.exp_ready = e_rdy; t.exp_en = e_en; t.exp_rsp_valid = e_rv;
    t.exp_rsp_data = e_rd; t.exp_addr_a = e_aa; t.exp_addr_b = e_ab;
    t.exp_wdata_a = e_wa;
    vecs.push_back(t);
  endtask

  logic [3:0] seq_exp [4];

  initial begin
    rst   = 1'b1;
    valid = '0;
    write = '0;
    addr  = '0;
    data  = '0;

    //       rst   valid    write    addr      data           rdy      en       rspv     rspdata        aA     aB     wdA
    // reset held three cycles with every client requesting
    add_vec(1'b1, 4'b1111, 4'b0000, 16'h4321, 32'h0,         4'b0000, 4'b0000, 4'b0000, 32'h0,         4'h0, 4'h0, 8'h00);
    add_vec(1'b1, 4'b1111, 4'b0000, 16'h4321, 32'h0,         4'b0000, 4'b0000, 4'b0000, 32'h0,         4'h0, 4'h0, 8'h00);
    add_vec(1'b1, 4'b1111, 4'b0000, 16'h4321, 32'h0,         4'b0000, 4'b0000, 4'b0000, 32'h0,         4'h0, 4'h0, 8'h00);
    // ptr=0: clients 0/1 on A/B
    add_vec(1'b0, 4'b1111, 4'b0000, 16'h4321, 32'h0,         4'b0011, 4'b0101, 4'b0000, 32'h0,         4'h1, 4'h2, 8'h00);
`ifndef BRAM_ARB_FIXED_PRIORITY_EN
    // ptr=2: clients 2/3, responses for 0/1
    add_vec(1'b0, 4'b1111, 4'b0000, 16'h4321, 32'h0,         4'b1100, 4'b0101, 4'b0011, 32'h0000_2211, 4'h3, 4'h4, 8'h00);
    add_vec(1'b0, 4'b0000, 4'b0000, 16'h0000, 32'h0,         4'b0000, 4'b0000, 4'b1100, 32'h4433_0000, 4'h0, 4'h0, 8'h00);
    // write conflict on address 5: serialised, last write wins
    add_vec(1'b0, 4'b0011, 4'b0011, 16'h0055, 32'h0000_BBAA, 4'b0001, 4'b0010, 4'b0000, 32'h0,         4'h5, 4'h0, 8'hAA);
    add_vec(1'b0, 4'b0010, 4'b0011, 16'h0055, 32'h0000_BBAA, 4'b0010, 4'b0010, 4'b0000, 32'h0,         4'h5, 4'h0, 8'hBB);
    add_vec(1'b0, 4'b0100, 4'b0000, 16'h0500, 32'h0,         4'b0100, 4'b0001, 4'b0000, 32'h0,         4'h5, 4'h0, 8'h00);
    add_vec(1'b0, 4'b0000, 4'b0000, 16'h0000, 32'h0,         4'b0000, 4'b0000, 4'b0100, 32'h00BB_0000, 4'h0, 4'h0, 8'h00);
    // read/write same address: read deferred, sees new data
    add_vec(1'b0, 4'b0101, 4'b0001, 16'h0707, 32'h0000_005C, 4'b0001, 4'b0010, 4'b0000, 32'h0,         4'h7, 4'h0, 8'h5C);
    add_vec(1'b0, 4'b0100, 4'b0000, 16'h0700, 32'h0,         4'b0100, 4'b0001, 4'b0000, 32'h0,         4'h7, 4'h0, 8'h00);
    add_vec(1'b0, 4'b0000, 4'b0000, 16'h0000, 32'h0,         4'b0000, 4'b0000, 4'b0100, 32'h005C_0000, 4'h0, 4'h0, 8'h00);
    // reset right after a read grant: response dropped, ptr back to 0
    add_vec(1'b0, 4'b0001, 4'b0000, 16'h0001, 32'h0,         4'b0001, 4'b0001, 4'b0000, 32'h0,         4'h1, 4'h0, 8'h00);
    add_vec(1'b1, 4'b0000, 4'b0000, 16'h0000, 32'h0,         4'b0000, 4'b0000, 4'b0000, 32'h0,         4'h0, 4'h0, 8'h00);
    add_vec(1'b0, 4'b0000, 4'b0000, 16'h0000, 32'h0,         4'b0000, 4'b0000, 4'b0000, 32'h0,         4'h0, 4'h0, 8'h00);
    add_vec(1'b0, 4'b1111, 4'b0000, 16'h4321, 32'h0,         4'b0011, 4'b0101, 4'b0000, 32'h0,         4'h1, 4'h2, 8'h00);
    add_vec(1'b0, 4'b0000, 4'b0000, 16'h0000, 32'h0,         4'b0000, 4'b0000, 4'b0011, 32'h0000_2211, 4'h0, 4'h0, 8'h00);
    // single requester uses port A only
    add_vec(1'b0, 4'b1000, 4'b0000, 16'h3000, 32'h0,         4'b1000, 4'b0001, 4'b0000, 32'h0,         4'h3, 4'h0, 8'h00);
    add_vec(1'b0, 4'b0000, 4'b0000, 16'h0000, 32'h0,         4'b0000, 4'b0000, 4'b1000, 32'h3300_0000, 4'h0, 4'h0, 8'h00);
    // two reads of one address share a cycle
    add_vec(1'b0, 4'b0011, 4'b0000, 16'h0044, 32'h0,         4'b0011, 4'b0101, 4'b0000, 32'h0,         4'h4, 4'h4, 8'h00);
    add_vec(1'b0, 4'b0000, 4'b0000, 16'h0000, 32'h0,         4'b0000, 4'b0000, 4'b0011, 32'h0000_4444, 4'h0, 4'h0, 8'h00);
    // all four write address 9: one per cycle in order 2,3,0,1
    add_vec(1'b0, 4'b1111, 4'b1111, 16'h9999, 32'h0403_0201, 4'b0100, 4'b0010, 4'b0000, 32'h0,         4'h9, 4'h0, 8'h03);
    add_vec(1'b0, 4'b1011, 4'b1111, 16'h9999, 32'h0403_0201, 4'b1000, 4'b0010, 4'b0000, 32'h0,         4'h9, 4'h0, 8'h04);
    add_vec(1'b0, 4'b0011, 4'b1111, 16'h9999, 32'h0403_0201, 4'b0001, 4'b0010, 4'b0000, 32'h0,         4'h9, 4'h0, 8'h01);
    add_vec(1'b0, 4'b0010, 4'b1111, 16'h9999, 32'h0403_0201, 4'b0010, 4'b0010, 4'b0000, 32'h0,         4'h9, 4'h0, 8'h02);
    add_vec(1'b0, 4'b0001, 4'b0000, 16'h0009, 32'h0,         4'b0001, 4'b0001, 4'b0000, 32'h0,         4'h9, 4'h0, 8'h00);
    add_vec(1'b0, 4'b0000, 4'b0000, 16'h0000, 32'h0,         4'b0000, 4'b0000, 4'b0001, 32'h0000_0002, 4'h0, 4'h0, 8'h00);
`endif

    foreach (vecs[i]) begin
      @(negedge clk);
      rst   = vecs[i].rst;
      valid = vecs[i].valid;
      write = vecs[i].write;
      addr  = vecs[i].addr;
      data  = vecs[i].data;
      #1;
      check("ready",     i, 32'(ready),                  32'(vecs[i].exp_ready));
      check("enables",   i, 32'({we_b, re_b, we_a, re_a}), 32'(vecs[i].exp_en));
      check("rsp_valid", i, 32'(rsp_valid),              32'(vecs[i].exp_rsp_valid));
      check("rsp_data",  i, rsp_data,                    vecs[i].exp_rsp_data);
      check("rd_addr_a", i, 32'(ra_a),                   32'(vecs[i].exp_addr_a));
      check("wr_addr_a", i, 32'(wa_a),                   32'(vecs[i].exp_addr_a));
      check("wr_data_a", i, 32'(wd_a),                   32'(vecs[i].exp_wdata_a));
      check("rd_addr_b", i, 32'(ra_b),                   32'(vecs[i].exp_addr_b));
      check("wr_addr_b", i, 32'(wa_b),                   32'(vecs[i].exp_addr_b));
      check("wr_data_b", i, 32'(wd_b),                   32'h0);
    end

    // Clients 0,1,3 reading distinct addresses continuously.
`ifdef BRAM_ARB_FIXED_PRIORITY_EN
    seq_exp = '{4'b0011, 4'b0011, 4'b0011, 4'b0011};
`else
    // pointer enters at 1: A/B = 1/3, 0/1, 3/0, 1/3
    seq_exp = '{4'b1010, 4'b0011, 4'b1001, 4'b1010};
`endif
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      rst   = 1'b0;
      valid = 4'b1011;
      write = 4'b0000;
      addr  = 16'h4021;
      data  = '0;
      #1;
      check("steady_ready", c, 32'(ready), 32'(seq_exp[c]));
    end

    @(negedge clk);
    valid = '0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
